// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and encodings for the hazard scoreboard.
package hazard_pkg;

    localparam int HAZ_RIDX_W = 5;
    localparam int HAZ_SLOT_W = 2;
    localparam int FWD_RF     = 0;
    localparam int RDY_ALU    = 0;
    localparam int RDY_LOAD   = 1;

    typedef struct packed {
        logic                  valid;
        logic [HAZ_RIDX_W-1:0] wreg;
        logic [HAZ_SLOT_W-1:0] rdy;
    } slot_t;

endpackage

// File: rtl/haz_src_match.sv
// haz_src_match: forward select and hazard flag for one decode operand against the writer chain.
// HAZ_FWD_EN enables forwarding; without it any in-flight match stalls decode until retirement.
module haz_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  slot_t [DEPTH-1:0]      slots,
    input  logic                   src_valid,
    input  logic [HAZ_RIDX_W-1:0]  src_reg,
    output logic [SEL_W-1:0]       fwd_sel,
    output logic                   haz
);

`ifdef HAZ_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic [SEL_W-1:0] sel;
    logic             hit;
    logic             late;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel  = SEL_W'(FWD_RF);
        hit  = 1'b0;
        late = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_valid && src_reg != '0 && slots[k].valid && slots[k].wreg == src_reg) begin
                sel  = SEL_W'(k + 1);
                hit  = 1'b1;
                late = HAZ_SLOT_W'(k) < slots[k].rdy;
            end
        end
        fwd_sel = FWD_EN ? sel : SEL_W'(FWD_RF);
        haz     = FWD_EN ? late : hit;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight GPR writer chain with forwarding selects and stall/flush controls.
// Forwarding behaviour is selected by HAZ_FWD_EN inside haz_src_match.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSRC    = 2,
    parameter int DEPTH   = 3,
    parameter int RIDX_W  = HAZ_RIDX_W,
    parameter int MP_SLOT = 1,
    parameter int SLOT_W  = $clog2(DEPTH),
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [RIDX_W-1:0]      issue_wreg,
    input  logic [SLOT_W-1:0]      issue_rdy,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*RIDX_W-1:0] src_reg,
    input  logic                   cache_stall,
    input  logic                   ex_busy,
    input  logic                   flush_jump,
    input  logic                   flush_mispred,
    input  logic                   flush_exc,
    output logic [NSRC*SEL_W-1:0]  fwd_sel,
    output logic                   stallF,
    output logic                   stallD,
    output logic [DEPTH-1:0]       stall_slot,
    output logic                   flushD,
    output logic [DEPTH-1:0]       flush_slot,
    output logic                   long_stall
);

    slot_t [DEPTH-1:0] slot_q;
    slot_t [DEPTH-1:0] slot_d;
    slot_t [DEPTH-1:0] kept;
    slot_t             ins;
    logic              mp;
    logic [NSRC-1:0]   haz;
    logic              data_haz;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        haz_src_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
            .slots     (slot_q),
            .src_valid (src_valid[i]),
            .src_reg   (src_reg[i*RIDX_W +: RIDX_W]),
            .fwd_sel   (fwd_sel[i*SEL_W +: SEL_W]),
            .haz       (haz[i])
        );
    end

    always_comb begin
        long_stall = cache_stall | ex_busy;
        data_haz   = |haz;
        stallF     = (~flush_exc & long_stall) | data_haz;
        stallD     = long_stall | data_haz;
        stall_slot = {DEPTH{cache_stall}};
        stall_slot[0] = long_stall;
        stall_slot[DEPTH-1] = ~flush_exc & cache_stall;
        flushD     = flush_exc | flush_mispred | (flush_jump & ~stallD);
        flush_slot = {DEPTH{flush_exc}};
        flush_slot[0] = flush_exc | (flush_mispred & ~long_stall) | data_haz;
    end

    // Mispredict kills are applied before movement, so frozen and shifted entries die alike.
    always_comb begin
        mp  = flush_mispred & ~flush_exc;
        ins = '{valid: issue_valid & issue_wen & (issue_wreg != '0) & ~mp,
                wreg: issue_wreg, rdy: issue_rdy};
        for (int k = 0; k < DEPTH; k++) begin
            kept[k] = slot_q[k];
            kept[k].valid = slot_q[k].valid & ~(mp & (k < MP_SLOT));
        end
        slot_d[0] = flush_exc ? '0 : long_stall ? kept[0] : data_haz ? '0 : ins;
        slot_d[1] = flush_exc ? '0 : cache_stall ? kept[1] : ex_busy ? '0 : kept[0];
        for (int k = 2; k < DEPTH; k++) begin
            slot_d[k] = flush_exc ? '0 : cache_stall ? kept[k] : kept[k-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) slot_q <= '0;
        else         slot_q <= slot_d;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of the hazard scoreboard in either forwarding build.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       issue_valid, issue_wen;
    logic [4:0] issue_wreg;
    logic [1:0] issue_rdy;
    logic [1:0] src_valid;
    logic [9:0] src_reg;
    logic       cache_stall, ex_busy, flush_jump, flush_mispred, flush_exc;
    logic [3:0] fwd_sel;
    logic       stallF, stallD, flushD, long_stall;
    logic [2:0] stall_slot, flush_slot;
    int         n_tests = 0;
    int         n_fail = 0;

    hazard_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_wreg(issue_wreg), .issue_rdy(issue_rdy),
        .src_valid(src_valid), .src_reg(src_reg),
        .cache_stall(cache_stall), .ex_busy(ex_busy), .flush_jump(flush_jump),
        .flush_mispred(flush_mispred), .flush_exc(flush_exc),
        .fwd_sel(fwd_sel), .stallF(stallF), .stallD(stallD),
        .stall_slot(stall_slot), .flushD(flushD), .flush_slot(flush_slot),
        .long_stall(long_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] r, input logic [1:0] rdy);
        issue_valid = v;
        issue_wen   = v;
        issue_wreg  = r;
        issue_rdy   = rdy;
    endtask

    task automatic set_src(input logic [1:0] v, input logic [4:0] a, input logic [4:0] b);
        src_valid = v;
        src_reg   = {b, a};
    endtask

    task automatic idle;
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b00, 5'd0, 5'd0);
        cache_stall = 1'b0; ex_busy = 1'b0; flush_jump = 1'b0;
        flush_mispred = 1'b0; flush_exc = 1'b0;
    endtask

    task automatic reset_dut;
        idle();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        #3;
        chk("rst_ctrl", {stallF, stallD, stall_slot, flushD, flush_slot, long_stall}, 0);
        chk("rst_fwd", fwd_sel, 0);
        resetn = 1'b1;
        tick();

        // ALU writer then back-to-back consumers of r5
        reset_dut();
        set_issue(1'b1, 5'd5, 2'(RDY_ALU));
        tick();
        set_issue(1'b0, 5'd0, 2'd0);
        for (int c = 0; c < 4; c++) begin
            set_src(2'b01, 5'd5, 5'd0);
            #1;
            chk($sformatf("alu_fwd%0d", c), fwd_sel[1:0], (FWD && c < 3) ? c + 1 : 0);
            chk($sformatf("alu_stall%0d", c), stallD, !FWD && c < 3);
            tick();
        end

        // load-use
        reset_dut();
        set_issue(1'b1, 5'd8, 2'(RDY_LOAD));
        tick();
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b01, 5'd8, 5'd0);
        #1;
        chk("ld_stall", {stallF, stallD, flush_slot[0]}, 3'b111);
        chk("ld_fwd0", fwd_sel[1:0], FWD ? 1 : 0);
        tick();
        chk("ld_fwd1", fwd_sel[1:0], FWD ? 2 : 0);
        chk("ld_release", {stallD, flush_slot[0]}, FWD ? 2'b00 : 2'b11);

        // youngest of two r3 writers wins
        reset_dut();
        set_issue(1'b1, 5'd3, 2'd0); tick();
        set_issue(1'b1, 5'd7, 2'd0); tick();
        set_issue(1'b1, 5'd3, 2'd0); tick();
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b11, 5'd3, 5'd7);
        #1;
        chk("young_fwd0", fwd_sel[1:0], FWD ? 1 : 0);
        chk("young_fwd1", fwd_sel[3:2], FWD ? 2 : 0);
        chk("young_stall", stallD, !FWD);

        // multicycle ALU holds slot 0 and bubbles slot 1
        reset_dut();
        set_issue(1'b1, 5'd11, 2'd0); tick();
        set_issue(1'b1, 5'd9, 2'd0); tick();
        set_issue(1'b1, 5'd10, 2'd0);
        ex_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("busy%0d", c), {stallF, stallD, stall_slot, long_stall}, 6'b11_001_1);
            tick();
        end
        ex_busy = 1'b0;
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b10, 5'd0, 5'd11);
        #1;
        chk("busy_retired", {stallD, fwd_sel[3:2]}, 0);
        set_src(2'b10, 5'd0, 5'd10);
        #1;
        chk("busy_noissue", {stallD, fwd_sel[3:2]}, 0);
        set_src(2'b01, 5'd9, 5'd0);
        #1;
        chk("busy_held_fwd", fwd_sel[1:0], FWD ? 1 : 0);
        chk("busy_held_stall", stallD, !FWD);

        // mispredict kills slot 0 and the issuing entry, slot 1 survives
        reset_dut();
        set_issue(1'b1, 5'd4, 2'd0); tick();
        set_issue(1'b1, 5'd6, 2'd0); tick();
        set_issue(1'b1, 5'd12, 2'd0);
        flush_mispred = 1'b1;
        #1;
        chk("mp_flush", {flushD, flush_slot}, 4'b1_001);
        tick();
        flush_mispred = 1'b0;
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b01, 5'd4, 5'd0);
        #1;
        chk("mp_survivor_fwd", fwd_sel[1:0], FWD ? 3 : 0);
        chk("mp_survivor_stall", stallD, !FWD);
        set_src(2'b10, 5'd0, 5'd6);
        #1;
        chk("mp_killed", {stallD, fwd_sel[3:2]}, 0);
        set_src(2'b10, 5'd0, 5'd12);
        #1;
        chk("mp_dropped", {stallD, fwd_sel[3:2]}, 0);

        // cache stall freezes; exception during cache stall clears everything
        reset_dut();
        set_issue(1'b1, 5'd2, 2'd0); tick();
        set_issue(1'b0, 5'd0, 2'd0);
        cache_stall = 1'b1;
        #1;
        chk("cs_stall", {stallF, stallD, stall_slot}, 5'b11_111);
        tick();
        cache_stall = 1'b0;
        set_src(2'b01, 5'd2, 5'd0);
        #1;
        chk("cs_frozen_fwd", fwd_sel[1:0], FWD ? 1 : 0);
        chk("cs_frozen_stall", stallD, !FWD);
        set_src(2'b00, 5'd0, 5'd0);
        cache_stall = 1'b1;
        flush_exc = 1'b1;
        #1;
        chk("exc_cs", {stallF, stallD, stall_slot, flushD, flush_slot}, 9'b0_1_011_1_111);
        tick();
        cache_stall = 1'b0;
        flush_exc = 1'b0;
        set_src(2'b01, 5'd2, 5'd0);
        #1;
        chk("exc_cleared", {stallD, fwd_sel}, 0);

        // r0 writer and non-writing issue never match; jump flush gated by stall
        reset_dut();
        set_issue(1'b1, 5'd0, 2'd0); tick();
        issue_valid = 1'b1; issue_wen = 1'b0; issue_wreg = 5'd5;
        tick();
        set_issue(1'b0, 5'd0, 2'd0);
        set_src(2'b01, 5'd0, 5'd0);
        #1;
        chk("r0_nomatch", {stallD, fwd_sel}, 0);
        set_src(2'b01, 5'd5, 5'd0);
        #1;
        chk("nowen_nomatch", {stallD, fwd_sel}, 0);
        set_src(2'b00, 5'd0, 5'd0);
        flush_jump = 1'b1;
        #1;
        chk("jump_flush", flushD, 1);
        cache_stall = 1'b1;
        #1;
        chk("jump_stalled", flushD, 0);
        flush_jump = 1'b0;
        cache_stall = 1'b0;

        // asynchronous reset in the middle of a cache stall
        reset_dut();
        set_issue(1'b1, 5'd13, 2'd0); tick();
        set_issue(1'b0, 5'd0, 2'd0);
        cache_stall = 1'b1;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        cache_stall = 1'b0;
        set_src(2'b01, 5'd13, 5'd0);
        #1;
        chk("midstall_reset", {stallD, fwd_sel}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
